pc_update_ctrl: RTL
===================

// Module: pc_update_ctrl
// PURPOSE
//  Multicycle sequencer owning every PC update: computes the pc_source select, pc_write, epc_write
//  and the exception-vector fetch sequence. Sits between the main control FSM (issues one request
//  per instruction phase) and the PC-source mux/PC/EPC registers. PCSource codes: 0 ALU_out, 1 ALUOut,
//  2 jump-concat, 3 MDR, 4 EPC, 5 exception vector (zero-extended byte from memory).
// PARAMETERS
//  MEM_LAT    2    cycles between mem_rd assertion and valid data in MDR (1..15)
//  VEC_OPC    253  memory byte address of the invalid-opcode handler vector
//  VEC_OVF    254  memory byte address of the overflow handler vector
//  VEC_DIV0   255  memory byte address of the divide-by-zero handler vector
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  req_valid   in   1  control FSM presents a PC-update request
//  req_ready   out  1  block idle and able to accept a request
//  req_kind    in   3  0 SEQ(PC+4) 1 BRANCH 2 JUMP 3 JR 4 RTE 5 EXC; other values = no-op
//  br_type     in   2  0 beq 1 bne 2 ble 3 bgt (used only for BRANCH)
//  alu_zero    in   1  ALU zero flag, sampled at acceptance
//  alu_gt      in   1  ALU greater-than flag, sampled at acceptance
//  exc_cause   in   3  one-hot {div0, ovf, opc}, sampled at acceptance of EXC
//  pc_source   out  3  select to PC-source mux
//  pc_write    out  1  PC load strobe
//  epc_write   out  1  EPC load strobe (EPC captures PC-4 externally)
//  vec_addr    out  32 memory address for vector fetch
//  mem_rd      out  1  memory read request for vector fetch
//  mdr_write   out  1  MDR load strobe at end of vector fetch
//  done        out  1  one-cycle pulse: request completed
//  br_taken    out  1  valid with done for BRANCH: 1 if PC was loaded
// BEHAVIOUR
//  - All outputs registered (Moore). Reset: state IDLE, req_ready=1, all other outputs 0, wait counter 0.
//  - Handshake: accept on rising edge with req_valid & req_ready; req_ready drops the next cycle and
//    returns high the cycle after done. Inputs are captured only at acceptance.
//  - States: IDLE, EXEC, EXC_EPC, EXC_VEC, EXC_WAIT, EXC_MDR, EXC_LOAD, FINISH.
//  - SEQ/JUMP/JR/RTE: IDLE->EXEC; in EXEC pc_write=1, pc_source=0/2/1/4 respectively, done=1;
//    EXEC->IDLE. Latency: accept at edge N, pc_write high in cycle N+1, ready again at N+2.
//  - BRANCH: taken = beq:zero, bne:!zero, ble:!gt, bgt:gt. In EXEC pc_source=1, pc_write=taken,
//    br_taken=taken, done=1. Not-taken is still a 1-cycle EXEC with pc_write=0.
//  - Invalid req_kind (6,7): EXEC with pc_write=0, done=1.
//  - EXC: EXC_EPC (epc_write=1) -> EXC_VEC (vec_addr driven, mem_rd=1) -> EXC_WAIT (mem_rd=1,
//    counts MEM_LAT-1 cycles; skipped when MEM_LAT=1) -> EXC_MDR (mdr_write=1) -> EXC_LOAD
//    (pc_source=5, pc_write=1, done=1) -> IDLE. Total 4+MEM_LAT cycles; vec_addr held stable
//    from EXC_VEC through EXC_MDR.
//  - exc_cause priority if multiple bits set: opc > ovf > div0. exc_cause==0 with EXC: treat as
//    opc. vec_addr = zero-extended 8-bit VEC_* value.
//  - Requests while busy are ignored (no queuing); caller must hold req_valid until req_ready.
//  - Reset mid-sequence: immediate return to IDLE, all strobes deasserted asynchronously; no
//    partial PC/EPC write beyond what already occurred.
//  - pc_source holds its last value when pc_write=0 (no glitching to 0 between requests).
// STRUCTURE
//  - Shared include pc_ctrl_defs.vh: PCSource codes, req_kind codes, br_type codes, state encodings.
//  - One sub-module: lat_counter (loadable down-counter, 4-bit, load/dec/zero) for EXC_WAIT.
//  - Main FSM, branch-condition decode and cause priority encoder stay in this module.
// TESTING
//  1 reset mid-EXC_WAIT -> next cycle all strobes 0, req_ready=1, state IDLE.
//  2 SEQ accepted edge 10 -> cycle 11: pc_write=1, pc_source=0, done=1; edge 12 req_ready=1.
//  3 BRANCH beq zero=1 -> pc_write=1 src=1 br_taken=1; bne zero=1 -> pc_write=0 br_taken=0 done=1.
//  4 BRANCH ble/bgt with gt=1 -> ble not taken, bgt taken; JUMP src=2, JR src=1, RTE src=4.
//  5 EXC cause=3'b110, MEM_LAT=2 -> epc_write, then vec_addr=254 mem_rd 2 cycles, mdr_write,
//    pc_write src=5 done; 6 cycles total; req_valid pulses during sequence ignored.
//  6 EXC cause=0 with MEM_LAT=1 -> vec_addr=253, EXC_WAIT skipped, 5 cycles total.

Source files
------------

// File: rtl/pc_update_ctrl_pkg.sv
// Shared definitions for the PC-update sequencer: PC-source, request-kind,
// branch-type and FSM state encodings, plus the branch and cause decoders.
package pc_update_ctrl_pkg;

  typedef enum logic [2:0] {
    SRC_ALU    = 3'd0,
    SRC_ALUOUT = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_MDR    = 3'd3,
    SRC_EPC    = 3'd4,
    SRC_VEC    = 3'd5
  } pc_src_e;

  typedef enum logic [2:0] {
    KIND_SEQ    = 3'd0,
    KIND_BRANCH = 3'd1,
    KIND_JUMP   = 3'd2,
    KIND_JR     = 3'd3,
    KIND_RTE    = 3'd4,
    KIND_EXC    = 3'd5
  } req_kind_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_LE = 2'd2,
    BR_GT = 2'd3
  } br_type_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_EXC_EPC  = 3'd2,
    S_EXC_VEC  = 3'd3,
    S_EXC_WAIT = 3'd4,
    S_EXC_MDR  = 3'd5,
    S_EXC_LOAD = 3'd6,
    S_FINISH   = 3'd7
  } state_e;

  function automatic logic branch_taken(input logic [1:0] br, input logic zero,
                                        input logic gt);
    logic taken;
    case (br)
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_LE:   taken = ~gt;
      default: taken = gt;
    endcase
    return taken;
  endfunction

  // Cause bits are {div0, ovf, opc}; opc wins, and an empty cause also maps to opc.
  function automatic logic [7:0] cause_vec(input logic [2:0] cause, input logic [7:0] v_opc,
                                           input logic [7:0] v_ovf, input logic [7:0] v_div0);
    logic [7:0] v;
    if (cause[0] || cause == 3'b000) v = v_opc;
    else if (cause[1])               v = v_ovf;
    else                             v = v_div0;
    return v;
  endfunction

endpackage

// File: rtl/pc_update_ctrl_if.sv
// Request/response bundle between the main control FSM (master) and the
// PC-update sequencer (slave), including the PC/EPC/MDR strobes.
interface pc_update_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [1:0]  br_type;
  logic        alu_zero;
  logic        alu_gt;
  logic [2:0]  exc_cause;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic [31:0] vec_addr;
  logic        mem_rd;
  logic        mdr_write;
  logic        done;
  logic        br_taken;

  modport master (
    output req_valid, req_kind, br_type, alu_zero, alu_gt, exc_cause,
    input  req_ready, pc_source, pc_write, epc_write, vec_addr, mem_rd,
           mdr_write, done, br_taken
  );

  modport slave (
    input  req_valid, req_kind, br_type, alu_zero, alu_gt, exc_cause,
    output req_ready, pc_source, pc_write, epc_write, vec_addr, mem_rd,
           mdr_write, done, br_taken
  );
endinterface

// File: rtl/pc_update_ctrl_lat_counter.sv
// Loadable 4-bit down-counter timing the memory-latency wait of the
// exception vector fetch; saturates at zero.
module lat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pc_update_ctrl.sv
// Multicycle sequencer owning every PC update: PC-source select, PC/EPC write
// strobes and the exception-vector fetch. All outputs are registered.
module pc_update_ctrl
  import pc_update_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [7:0]  VEC_OPC  = 8'd253,
  parameter logic [7:0]  VEC_OVF  = 8'd254,
  parameter logic [7:0]  VEC_DIV0 = 8'd255
) (
  input  logic            clk,
  input  logic            reset,
  pc_update_ctrl_if.slave bus
);

  localparam logic [3:0] LAT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e      r_state, w_next;
  logic [2:0]  r_kind;
  logic        r_taken;
  logic [7:0]  r_vec;

  logic        r_req_ready, w_req_ready;
  pc_src_e     r_pc_source, w_pc_source;
  logic        r_pc_write, w_pc_write;
  logic        r_epc_write, w_epc_write;
  logic [31:0] r_vec_addr, w_vec_addr;
  logic        r_mem_rd, w_mem_rd;
  logic        r_mdr_write, w_mdr_write;
  logic        r_done, w_done;
  logic        r_br_taken, w_br_taken;

  logic        w_accept;
  logic [2:0]  w_kind;
  logic        w_taken;
  logic        w_cnt_zero;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  // Outputs are registered from the next state, so the EXEC decode must see the
  // request fields live on the accepting edge rather than their captured copies.
  assign w_kind   = w_accept ? bus.req_kind : r_kind;
  assign w_taken  = w_accept ? branch_taken(bus.br_type, bus.alu_zero, bus.alu_gt) : r_taken;

  lat_counter #(.WIDTH(4)) u_lat (
    .clk        (clk),
    .rst        (reset),
    .i_load     (r_state == S_EXC_VEC),
    .i_load_val (LAT_LOAD),
    .i_dec      (r_state == S_EXC_WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.req_valid) w_next = (bus.req_kind == KIND_EXC) ? S_EXC_EPC : S_EXEC;
      S_EXEC:     w_next = S_IDLE;
      S_EXC_EPC:  w_next = S_EXC_VEC;
      S_EXC_VEC:  w_next = (MEM_LAT > 1) ? S_EXC_WAIT : S_EXC_MDR;
      S_EXC_WAIT: if (w_cnt_zero) w_next = S_EXC_MDR;
      S_EXC_MDR:  w_next = S_EXC_LOAD;
      S_EXC_LOAD: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_pc_source = r_pc_source;
    w_pc_write  = 1'b0;
    w_epc_write = 1'b0;
    w_vec_addr  = r_vec_addr;
    w_mem_rd    = 1'b0;
    w_mdr_write = 1'b0;
    w_done      = 1'b0;
    w_br_taken  = 1'b0;
    case (w_next)
      S_IDLE: w_req_ready = 1'b1;
      S_EXEC: begin
        w_done = 1'b1;
        case (w_kind)
          KIND_SEQ:    begin w_pc_write = 1'b1; w_pc_source = SRC_ALU;  end
          KIND_JUMP:   begin w_pc_write = 1'b1; w_pc_source = SRC_JUMP; end
          KIND_JR:     begin w_pc_write = 1'b1; w_pc_source = SRC_ALUOUT; end
          KIND_RTE:    begin w_pc_write = 1'b1; w_pc_source = SRC_EPC;  end
          KIND_BRANCH: begin
            w_pc_write = w_taken;
            w_br_taken = w_taken;
            if (w_taken) w_pc_source = SRC_ALUOUT;
          end
          default: ;
        endcase
      end
      S_EXC_EPC:  w_epc_write = 1'b1;
      S_EXC_VEC:  begin w_mem_rd = 1'b1; w_vec_addr = {24'd0, r_vec}; end
      S_EXC_WAIT: w_mem_rd = 1'b1;
      S_EXC_MDR:  w_mdr_write = 1'b1;
      S_EXC_LOAD: begin w_pc_write = 1'b1; w_pc_source = SRC_VEC; w_done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind      <= '0;
      r_taken     <= 1'b0;
      r_vec       <= '0;
      r_req_ready <= 1'b1;
      r_pc_source <= SRC_ALU;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_vec_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mdr_write <= 1'b0;
      r_done      <= 1'b0;
      r_br_taken  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_kind  <= bus.req_kind;
        r_taken <= branch_taken(bus.br_type, bus.alu_zero, bus.alu_gt);
        r_vec   <= cause_vec(bus.exc_cause, VEC_OPC, VEC_OVF, VEC_DIV0);
      end
      r_req_ready <= w_req_ready;
      r_pc_source <= w_pc_source;
      r_pc_write  <= w_pc_write;
      r_epc_write <= w_epc_write;
      r_vec_addr  <= w_vec_addr;
      r_mem_rd    <= w_mem_rd;
      r_mdr_write <= w_mdr_write;
      r_done      <= w_done;
      r_br_taken  <= w_br_taken;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.pc_source = r_pc_source;
  assign bus.pc_write  = r_pc_write;
  assign bus.epc_write = r_epc_write;
  assign bus.vec_addr  = r_vec_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mdr_write = r_mdr_write;
  assign bus.done      = r_done;
  assign bus.br_taken  = r_br_taken;

endmodule
